// File: rtl/sram_tile_sched_if.sv
// Tile push (host/DMA) and pop (systolic array) valid/ready channels.
// The master drives pushes and pop requests, and the slave is the scheduler.
interface sram_tile_sched_if #(
  parameter int TW = 128
);
  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_data;
  logic          out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/sram_tile_sched.sv
// Circular K-slot tile queue controller that sits in front of the tile SRAM register file.
// Optional feature: define TILE_REPLAY_EN to make each head tile pop REPLAY times before its slot is freed.
module sram_tile_sched #(
  parameter int N      = 4,
  parameter int K      = 8,
  parameter int REPLAY = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  sram_tile_sched_if.slave       bus,
  output logic [$clog2(K):0]     o_occupancy,
  output logic                   o_sram_we,
  output logic                   o_sram_reg_in,
  output logic [$clog2(K)-1:0]   o_sram_waddr,
  output logic [8*N*N-1:0]       o_sram_wdata,
  output logic [$clog2(K)-1:0]   o_sram_raddr,
  input  logic [8*N*N-1:0]       i_sram_rdata
);
  localparam int AW = $clog2(K);
  localparam int OW = AW + 1;

  if (K < 2 || (K & (K - 1)) != 0) begin : g_bad_k
    $error("sram_tile_sched: K must be a power of two >= 2");
  end
  if (REPLAY < 1) begin : g_bad_replay
    $error("sram_tile_sched: REPLAY must be >= 1");
  end

  typedef enum logic [1:0] {EMPTY, AVAIL, FULL} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [OW-1:0]   r_occ;
  logic [OW-1:0]   w_occ_next;
  logic            w_in_ready;
  logic            w_out_valid;
  logic            w_push;
  logic            w_pop;
  logic            w_last;
  logic            w_free;

  assign w_push = bus.in_valid & w_in_ready;
  assign w_pop  = w_out_valid & bus.out_ready;
  assign w_free = w_pop & w_last;

`ifdef TILE_REPLAY_EN
  localparam int RW = $clog2(REPLAY + 1);
  logic [RW-1:0] r_replay_cnt;

  assign w_last = (r_replay_cnt == RW'(REPLAY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_replay_cnt <= '0;
    end else if (i_flush) begin
      r_replay_cnt <= '0;
    end else if (w_pop) begin
      r_replay_cnt <= w_last ? '0 : r_replay_cnt + RW'(1);
    end
  end
`else
  assign w_last = 1'b1;
`endif

  // Occupancy moves only when exactly one of push/free happens.
  always_comb begin
    w_occ_next = r_occ;
    if (w_push && !w_free) begin
      w_occ_next = r_occ + OW'(1);
    end else if (!w_push && w_free) begin
      w_occ_next = r_occ - OW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_free) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_occ <= w_occ_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= EMPTY;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (i_flush || w_occ_next == '0) begin
      w_state_next = EMPTY;
    end else if (w_occ_next == OW'(K)) begin
      w_state_next = FULL;
    end else begin
      w_state_next = AVAIL;
    end
  end

  // A flush masks both handshakes, so nothing moves during that cycle.
  always_comb begin
    w_in_ready  = (r_state != FULL)  & ~i_flush;
    w_out_valid = (r_state != EMPTY) & ~i_flush;
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = i_sram_rdata;
  assign bus.out_last  = w_last;

  assign o_occupancy   = r_occ;
  assign o_sram_we     = w_push;
  assign o_sram_reg_in = w_push;
  assign o_sram_waddr  = r_wr_ptr;
  assign o_sram_wdata  = bus.in_data;
  assign o_sram_raddr  = r_rd_ptr;
endmodule

// File: tb/tb_sram_tile_sched.sv
// Bench for sram_tile_sched: a table of vectors, hand-written corner sequences and a random run.
// A queue-level model of the tile FIFO produces the expected values, and a small array models the SRAM.
module tb_sram_tile_sched;
  localparam int N      = 4;
  localparam int K      = 8;
  localparam int REPLAY = 4;
  localparam int TW     = 8 * N * N;
  localparam int AW     = $clog2(K);

  typedef logic [TW-1:0] tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_flush = 1'b0;
  logic [AW:0]   o_occupancy;
  logic          o_sram_we;
  logic          o_sram_reg_in;
  logic [AW-1:0] o_sram_waddr;
  tile_t         o_sram_wdata;
  logic [AW-1:0] o_sram_raddr;
  tile_t         i_sram_rdata;

  sram_tile_sched_if #(.TW(TW)) bus ();

  sram_tile_sched #(.N(N), .K(K), .REPLAY(REPLAY)) dut (
    .clk           (clk),
    .rst           (rst),
    .i_flush       (i_flush),
    .bus           (bus.slave),
    .o_occupancy   (o_occupancy),
    .o_sram_we     (o_sram_we),
    .o_sram_reg_in (o_sram_reg_in),
    .o_sram_waddr  (o_sram_waddr),
    .o_sram_wdata  (o_sram_wdata),
    .o_sram_raddr  (o_sram_raddr),
    .i_sram_rdata  (i_sram_rdata)
  );

  always #5 clk = ~clk;

  tile_t mem [K];
  always @(posedge clk) if (o_sram_we) mem[o_sram_waddr] <= o_sram_wdata;
  assign i_sram_rdata = mem[o_sram_raddr];

  int checks = 0;
  int failures = 0;

  // The model keeps the queued tiles in arrival order.
  tile_t q[$];
  int    wrCnt = 0;
  int    rdCnt = 0;
  int    rep   = 0;
  logic  curPush, curPop, curLast, curFlush;
  tile_t curData;

  function automatic tile_t mkTile(input logic [7:0] tag);
    return {(TW/8){tag}};
  endfunction

  task automatic checkOutput(input string name, input tile_t act, input tile_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelClear();
    q.delete();
    wrCnt = 0;
    rdCnt = 0;
    rep   = 0;
  endtask

  // Drive one cycle of inputs and check the settled outputs against the model.
  task automatic applyStimulus(input logic v, input tile_t d, input logic r, input logic f);
    logic expIn, expOut;
    i_flush       = f;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    expIn  = (q.size() < K) && !f;
    expOut = (q.size() > 0) && !f;
`ifdef TILE_REPLAY_EN
    curLast = (rep == REPLAY - 1);
`else
    curLast = 1'b1;
`endif
    curPush  = v && expIn;
    curPop   = expOut && r;
    curFlush = f;
    curData  = d;
    checkOutput("in_ready", tile_t'(bus.in_ready), tile_t'(expIn));
    checkOutput("out_valid", tile_t'(bus.out_valid), tile_t'(expOut));
    checkOutput("occupancy", tile_t'(o_occupancy), tile_t'(q.size()));
    checkOutput("sram_we", tile_t'(o_sram_we), tile_t'(curPush));
    checkOutput("sram_reg_in", tile_t'(o_sram_reg_in), tile_t'(curPush));
    checkOutput("sram_raddr", tile_t'(o_sram_raddr), tile_t'(rdCnt % K));
    if (curPush) begin
      checkOutput("sram_waddr", tile_t'(o_sram_waddr), tile_t'(wrCnt % K));
      checkOutput("sram_wdata", o_sram_wdata, d);
    end
    if (expOut) begin
      checkOutput("out_data", bus.out_data, q[0]);
      checkOutput("out_last", tile_t'(bus.out_last), tile_t'(curLast));
    end
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
    if (curFlush) begin
      modelClear();
    end else begin
      if (curPop) begin
        if (curLast) begin
          void'(q.pop_front());
          rdCnt++;
          rep = 0;
        end else begin
          rep++;
        end
      end
      if (curPush) begin
        q.push_back(curData);
        wrCnt++;
      end
    end
  endtask

  task automatic doCycle(input logic v, input tile_t d, input logic r, input logic f);
    applyStimulus(v, d, r, f);
    stepClock();
  endtask

  task automatic doReset();
    rst           = 1'b1;
    i_flush       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("rst_occupancy", tile_t'(o_occupancy), '0);
    checkOutput("rst_in_ready", tile_t'(bus.in_ready), tile_t'(1));
    checkOutput("rst_out_valid", tile_t'(bus.out_valid), '0);
    checkOutput("rst_sram_we", tile_t'(o_sram_we), '0);
    checkOutput("rst_sram_reg_in", tile_t'(o_sram_reg_in), '0);
    modelClear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    repeat (K * REPLAY + 2) doCycle(1'b0, '0, 1'b1, 1'b0);
  endtask

  typedef struct {
    logic       v;
    logic       r;
    logic [7:0] tag;
    logic       expIn;
    logic       expOut;
    int         expOcc;
    logic [7:0] expTag;
  } vec_t;

  initial begin
    vec_t vecs[7];
    tile_t rt;

    doReset();

`ifndef TILE_REPLAY_EN
    vecs[0] = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 0, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 8'hB2, 1'b1, 1'b1, 1, 8'hA1};
    vecs[2] = '{1'b1, 1'b0, 8'hC3, 1'b1, 1'b1, 2, 8'hA1};
    vecs[3] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 3, 8'hA1};
    vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 2, 8'hB2};
    vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1, 8'hC3};
    vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h00};
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].v, mkTile(vecs[i].tag), vecs[i].r, 1'b0);
      checkOutput("vec_in_ready", tile_t'(bus.in_ready), tile_t'(vecs[i].expIn));
      checkOutput("vec_out_valid", tile_t'(bus.out_valid), tile_t'(vecs[i].expOut));
      checkOutput("vec_occupancy", tile_t'(o_occupancy), tile_t'(vecs[i].expOcc));
      if (vecs[i].expOut) checkOutput("vec_out_data", bus.out_data, mkTile(vecs[i].expTag));
      stepClock();
    end
`endif

    // Fill to K, then a push and a pop together: only the pop goes through.
    for (int i = 0; i < K; i++) doCycle(1'b1, mkTile(8'h20 + 8'(i)), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("full_in_ready", tile_t'(bus.in_ready), '0);
    stepClock();
    applyStimulus(1'b1, mkTile(8'h77), 1'b1, 1'b0);
    checkOutput("full_no_push", tile_t'(o_sram_we), '0);
    stepClock();
`ifndef TILE_REPLAY_EN
    checkOutput("full_pop_occ", tile_t'(o_occupancy), tile_t'(K - 1));
`endif
    drain();

    // With one tile held, push and pop in the same cycle.
    doCycle(1'b1, mkTile(8'h30), 1'b0, 1'b0);
    applyStimulus(1'b1, mkTile(8'h31), 1'b1, 1'b0);
    checkOutput("collide_addr", tile_t'(o_sram_waddr != o_sram_raddr), tile_t'(1));
    stepClock();
`ifndef TILE_REPLAY_EN
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("pushpop_occ", tile_t'(o_occupancy), tile_t'(1));
    checkOutput("pushpop_data", bus.out_data, mkTile(8'h31));
    stepClock();
`endif
    drain();

    for (int i = 0; i < 20; i++) doCycle(1'b1, mkTile(8'h40 + 8'(i)), 1'b1, 1'b0);
    drain();

    // Flush at occupancy 5 while a push is being offered.
    for (int i = 0; i < 5; i++) doCycle(1'b1, mkTile(8'h60 + 8'(i)), 1'b0, 1'b0);
    applyStimulus(1'b1, mkTile(8'h6F), 1'b1, 1'b1);
    checkOutput("flush_no_we", tile_t'(o_sram_we), '0);
    stepClock();
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("flush_occ", tile_t'(o_occupancy), '0);
    checkOutput("flush_out_valid", tile_t'(bus.out_valid), '0);
    checkOutput("flush_in_ready", tile_t'(bus.in_ready), tile_t'(1));
    stepClock();

    for (int i = 0; i < 3; i++) doCycle(1'b1, mkTile(8'h70 + 8'(i)), 1'b0, 1'b0);
    doReset();

`ifdef TILE_REPLAY_EN
    doCycle(1'b1, mkTile(8'hAA), 1'b0, 1'b0);
    doCycle(1'b1, mkTile(8'hBB), 1'b0, 1'b0);
    for (int p = 0; p < 2 * REPLAY; p++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      checkOutput("replay_data", bus.out_data, mkTile(p < REPLAY ? 8'hAA : 8'hBB));
      checkOutput("replay_last", tile_t'(bus.out_last), tile_t'((p % REPLAY) == REPLAY - 1));
      checkOutput("replay_occ", tile_t'(o_occupancy), tile_t'(p < REPLAY ? 2 : 1));
      stepClock();
    end
    checkOutput("replay_empty", tile_t'(o_occupancy), '0);
    doCycle(1'b1, mkTile(8'hCC), 1'b0, 1'b0);
    doCycle(1'b0, '0, 1'b1, 1'b0);
    doCycle(1'b0, '0, 1'b1, 1'b0);
    doReset();
    doCycle(1'b1, mkTile(8'hDD), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("replay_cnt_reset", tile_t'(bus.out_last), '0);
    stepClock();
    drain();
`endif

    for (int i = 0; i < 400; i++) begin
      rt = {$urandom(), $urandom(), $urandom(), $urandom()};
      doCycle(1'($urandom % 2), rt, 1'($urandom % 2), 1'(($urandom % 40) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
